face_match_tracker: RTL and testbench

- Sits directly downstream of the 32x32 SAD unit in the findface datapath. Consumes its `sad` result stream.
- Keeps a 4-stage (PIPE_LAT) delay line of candidate valid and coordinates so each `sad` is matched to the window that produced it.
- Tracks the minimum SAD and its (x, y) position over one scan of the group image.
- Signals completion to the IPIF register/control logic with `busy` and `done`.

---
 rtl/face_match_tracker_if.sv | 30 +++
 rtl/face_match_tracker.sv | 106 ++++++++++
 tb/tb_face_match_tracker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/face_match_tracker_if.sv
// Bus between the SAD datapath/control logic and face_match_tracker:
// candidate stream and SAD in, best-match result and status out.
interface face_match_tracker_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 20,
  parameter int SAD_W   = 32
);
  logic               start;
  logic [CNT_W-1:0]   num_cand;
  logic               cand_valid;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic [SAD_W-1:0]   sad;
  logic               busy;
  logic               done;
  logic [SAD_W-1:0]   best_sad;
  logic [COORD_W-1:0] best_x;
  logic [COORD_W-1:0] best_y;
  logic [CNT_W-1:0]   res_count;

  modport master (
    output start, num_cand, cand_valid, cand_x, cand_y, sad,
    input  busy, done, best_sad, best_x, best_y, res_count
  );

  modport slave (
    input  start, num_cand, cand_valid, cand_x, cand_y, sad,
    output busy, done, best_sad, best_x, best_y, res_count
  );
endinterface

// File: rtl/face_match_tracker.sv
// Follows the SAD unit: delays candidate coordinates to line up with each sad
// result and keeps the minimum SAD and its position over one scan.
module face_match_tracker #(
  parameter int PIPE_LAT = 4,
  parameter int COORD_W  = 10,
  parameter int CNT_W    = 20,
  parameter int SAD_W    = 32
) (
  input  logic Bus2IP_Clk,
  input  logic Bus2IP_Reset,
  face_match_tracker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   num_cand_q;
  logic [CNT_W-1:0]   issue_cnt_q;
  logic [CNT_W-1:0]   res_count_q;
  logic [SAD_W-1:0]   best_sad_q;
  logic [COORD_W-1:0] best_x_q;
  logic [COORD_W-1:0] best_y_q;
  logic [PIPE_LAT-1:0] pipe_vld_q;
  logic [COORD_W-1:0] pipe_x_q [PIPE_LAT];
  logic [COORD_W-1:0] pipe_y_q [PIPE_LAT];
  logic               issue;
  logic               consume;
  logic               last_result;
  logic               better;

  assign better = bus.sad < best_sad_q;

  // A start pulse always wins over issue and consume in the same cycle.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    consume     = 1'b0;
    last_result = 1'b0;
    if (state_q == SCAN && !bus.start) begin
      issue       = bus.cand_valid && (issue_cnt_q < num_cand_q);
      consume     = pipe_vld_q[PIPE_LAT-1];
      last_result = consume && (res_count_q + CNT_W'(1) == num_cand_q);
    end
    if (bus.start) begin
      state_d = (bus.num_cand != '0) ? SCAN : DONE;
    end else if (last_result) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q     <= IDLE;
      num_cand_q  <= '0;
      issue_cnt_q <= '0;
      res_count_q <= '0;
      best_sad_q  <= '1;
      best_x_q    <= '0;
      best_y_q    <= '0;
      pipe_vld_q  <= '0;
    end else begin
      state_q <= state_d;
      if (bus.start) begin
        num_cand_q  <= bus.num_cand;
        issue_cnt_q <= '0;
        res_count_q <= '0;
        best_sad_q  <= '1;
        best_x_q    <= '0;
        best_y_q    <= '0;
        pipe_vld_q  <= '0;
      end else begin
        pipe_vld_q <= {pipe_vld_q[PIPE_LAT-2:0], issue};
        if (issue) begin
          issue_cnt_q <= issue_cnt_q + CNT_W'(1);
        end
        // Strict compare keeps the earliest candidate on ties.
        if (consume) begin
          res_count_q <= res_count_q + CNT_W'(1);
          if (better) begin
            best_sad_q <= bus.sad;
            best_x_q   <= pipe_x_q[PIPE_LAT-1];
            best_y_q   <= pipe_y_q[PIPE_LAT-1];
          end
        end
      end
    end
  end

  // Coordinates are qualified by pipe_vld_q, so they need no reset.
  always_ff @(posedge Bus2IP_Clk) begin
    pipe_x_q[0] <= bus.cand_x;
    pipe_y_q[0] <= bus.cand_y;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_x_q[i] <= pipe_x_q[i-1];
      pipe_y_q[i] <= pipe_y_q[i-1];
    end
  end

  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.best_sad  = best_sad_q;
  assign bus.best_x    = best_x_q;
  assign bus.best_y    = best_y_q;
  assign bus.res_count = res_count_q;

endmodule

// File: tb/tb_face_match_tracker.sv
// Bench for face_match_tracker: a SAD-unit model feeds delayed sad values and a
// per-scan reference computes the expected minimum, its position and done timing.
module tb_face_match_tracker;
  localparam int PIPE_LAT = 4;
  localparam int COORD_W  = 10;
  localparam int CNT_W    = 20;
  localparam int SAD_W    = 32;

  logic Bus2IP_Clk   = 1'b0;
  logic Bus2IP_Reset = 1'b1;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int done_cyc  = -1;
  bit busy_seen = 1'b0;

  logic [SAD_W-1:0]   hist[$];
  int                 op_q[$];
  logic [SAD_W-1:0]   sad_q[$];
  logic [COORD_W-1:0] x_q[$];
  logic [COORD_W-1:0] y_q[$];

  face_match_tracker_if #(.COORD_W(COORD_W), .CNT_W(CNT_W), .SAD_W(SAD_W)) bus ();

  face_match_tracker #(
    .PIPE_LAT(PIPE_LAT), .COORD_W(COORD_W), .CNT_W(CNT_W), .SAD_W(SAD_W)
  ) dut (
    .Bus2IP_Clk  (Bus2IP_Clk),
    .Bus2IP_Reset(Bus2IP_Reset),
    .bus         (bus)
  );

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic step();
    @(posedge Bus2IP_Clk);
    #1;
    cyc++;
    if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  endtask

  // The SAD unit answers for the window shown PIPE_LAT cycles earlier.
  task automatic present(input logic v, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                         input logic [SAD_W-1:0] win_sad);
    bus.cand_valid = v;
    bus.cand_x     = x;
    bus.cand_y     = y;
    bus.sad        = (hist.size() >= PIPE_LAT) ? hist[hist.size()-PIPE_LAT] : SAD_W'($urandom);
    hist.push_back(win_sad);
  endtask

  function automatic logic [COORD_W-1:0] rnd_coord();
    return COORD_W'($urandom);
  endfunction

  task automatic add_slot(input int op, input logic [SAD_W-1:0] s, input int x, input int y);
    op_q.push_back(op);
    sad_q.push_back(s);
    x_q.push_back(COORD_W'(x));
    y_q.push_back(COORD_W'(y));
  endtask

  // Slot ops: 0 idle, 1 candidate with sad_q value, 2 restart with num_cand = sad_q value.
  task automatic applyStimulus(input string tag, input int n);
    int n_cur, acc, exp_done, start_cyc, last_cyc;
    logic [SAD_W-1:0]   best;
    logic [COORD_W-1:0] bx, by;
    n_cur = n; acc = 0; start_cyc = 0; last_cyc = -1;
    best = '1; bx = '0; by = '0;
    cyc = 0; done_cyc = -1; busy_seen = 1'b0;
    hist.delete();
    bus.start = 1'b1;
    bus.num_cand = CNT_W'(n);
    present(1'b0, rnd_coord(), rnd_coord(), SAD_W'($urandom));
    step();
    bus.start = 1'b0;
    checkOutput({tag, "_busy_c1"}, 64'(bus.busy), 64'(n != 0));
    checkOutput({tag, "_done_c1"}, 64'(bus.done), 64'(n == 0));
    foreach (op_q[i]) begin
      if (op_q[i] == 2) begin
        bus.start = 1'b1;
        bus.num_cand = CNT_W'(sad_q[i]);
        n_cur = int'(sad_q[i]); acc = 0; last_cyc = -1; start_cyc = cyc;
        best = '1; bx = '0; by = '0; done_cyc = -1;
        present(1'b0, x_q[i], y_q[i], SAD_W'($urandom));
      end else begin
        present(op_q[i] == 1, x_q[i], y_q[i], (op_q[i] == 1) ? sad_q[i] : SAD_W'($urandom));
        if (op_q[i] == 1 && acc < n_cur) begin
          acc++;
          last_cyc = cyc;
          if (sad_q[i] < best) begin
            best = sad_q[i]; bx = x_q[i]; by = y_q[i];
          end
        end
      end
      step();
      bus.start = 1'b0;
    end
    exp_done = (n_cur == 0) ? start_cyc + 1 : last_cyc + PIPE_LAT + 1;
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      present(1'b0, rnd_coord(), rnd_coord(), SAD_W'($urandom));
      step();
    end
    repeat (2) begin
      present(1'b0, rnd_coord(), rnd_coord(), SAD_W'($urandom));
      step();
    end
    checkOutput({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    checkOutput({tag, "_done_held"}, 64'(bus.done), 64'd1);
    checkOutput({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_busy_seen"}, 64'(busy_seen), 64'(n_cur != 0 || n != 0));
    checkOutput({tag, "_best_sad"}, 64'(bus.best_sad), 64'(best));
    checkOutput({tag, "_best_x"}, 64'(bus.best_x), 64'(bx));
    checkOutput({tag, "_best_y"}, 64'(bus.best_y), 64'(by));
    checkOutput({tag, "_res_count"}, 64'(bus.res_count), 64'(n_cur));
    op_q.delete(); sad_q.delete(); x_q.delete(); y_q.delete();
  endtask

  task automatic applyResetMidScan();
    cyc = 0;
    hist.delete();
    bus.start = 1'b1;
    bus.num_cand = CNT_W'(4);
    present(1'b0, rnd_coord(), rnd_coord(), SAD_W'($urandom));
    step();
    bus.start = 1'b0;
    present(1'b1, 10'd3, 10'd4, 32'd7);
    step();
    present(1'b1, 10'd5, 10'd6, 32'd8);
    step();
    Bus2IP_Reset = 1'b1;
    present(1'b0, rnd_coord(), rnd_coord(), SAD_W'($urandom));
    step();
    Bus2IP_Reset = 1'b0;
    done_cyc = -1;
    busy_seen = 1'b0;
    repeat (10) begin
      present(1'b0, rnd_coord(), rnd_coord(), SAD_W'($urandom));
      step();
    end
    checkOutput("rst_mid_no_done", 64'(done_cyc), 64'(-1));
    checkOutput("rst_mid_busy", 64'(busy_seen), 64'd0);
    checkOutput("rst_mid_best_sad", 64'(bus.best_sad), 64'hFFFF_FFFF);
    checkOutput("rst_mid_res_count", 64'(bus.res_count), 64'd0);
  endtask

  initial begin
    int n, extra, cnt;
    bus.start = 1'b0; bus.num_cand = '0; bus.cand_valid = 1'b0;
    bus.cand_x = '0; bus.cand_y = '0; bus.sad = '0;
    Bus2IP_Reset = 1'b1;
    step();
    step();
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_best_sad", 64'(bus.best_sad), 64'hFFFF_FFFF);
    checkOutput("rst_best_x", 64'(bus.best_x), 64'd0);
    checkOutput("rst_best_y", 64'(bus.best_y), 64'd0);
    checkOutput("rst_res_count", 64'(bus.res_count), 64'd0);
    Bus2IP_Reset = 1'b0;

    add_slot(1, 500, 0, 0); add_slot(1, 200, 1, 0); add_slot(1, 300, 2, 0);
    applyStimulus("basic", 3);

    add_slot(1, 100, 7, 9); add_slot(0, 0, 0, 0); add_slot(0, 0, 0, 0);
    add_slot(1, 100, 8, 9); add_slot(1, 150, 3, 3);
    applyStimulus("tie", 3);

    // Candidates while DONE must not disturb the held result.
    repeat (3) begin
      present(1'b1, rnd_coord(), rnd_coord(), 32'd1);
      step();
    end
    checkOutput("idle_done_held", 64'(bus.done), 64'd1);
    checkOutput("idle_res_count", 64'(bus.res_count), 64'd3);
    add_slot(1, 40, 1, 1); add_slot(1, 30, 2, 2); add_slot(1, 5, 3, 3);
    applyStimulus("ovf", 2);

    applyStimulus("zero", 0);

    add_slot(1, 10, 1, 1); add_slot(1, 20, 2, 2); add_slot(0, 0, 0, 0);
    add_slot(2, 1, 0, 0); add_slot(1, 900, 4, 5);
    applyStimulus("abort", 4);

    applyResetMidScan();

    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(0, 6);
      extra = $urandom_range(0, 1);
      cnt = 0;
      while (cnt < n + extra) begin
        if ($urandom_range(0, 2) == 0) begin
          add_slot(0, 0, 0, 0);
        end else begin
          add_slot(1, SAD_W'($urandom_range(0, 15) * 17000), int'(rnd_coord()), int'(rnd_coord()));
          cnt++;
        end
      end
      applyStimulus($sformatf("rnd%0d", it), n);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
